// File: rtl/ldst_sequencer.sv
// ldst_sequencer: multi-cycle load/store controller between EX and the
// single-port data memory. One request in flight at a time; memory strobes,
// address and data are registered. Loads finish with a one-cycle register-file
// write-back; a wait counter aborts transactions the memory never acks.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   req_*                 EX request (valid/ready handshake), write=1 store
//   stall                 pipeline hold while a transaction is in flight
//   data_memory_*         memory address/data/strobes out, read data in
//   mem_ack               memory completion
//   w_enable/select/dest/other  register-file write-back for loads
//   err_timeout           one-cycle pulse: transaction aborted
//   err_misalign          one-cycle pulse: misaligned request rejected
module ldst_sequencer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dest,
  output logic        req_ready,
  output logic        stall,
  output logic [31:0] data_memory_a,
  output logic [31:0] data_memory_out_v,
  output logic        data_memory_read,
  output logic        data_memory_write,
  input  logic [31:0] data_memory_in_v,
  input  logic        mem_ack,
  output logic        w_enable,
  output logic        w_select,
  output logic [2:0]  w_dest,
  output logic [31:0] w_other,
  output logic        err_timeout,
  output logic        err_misalign
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, WB} state_t;

  localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [2:0]  r_dest;
  logic [31:0] r_addr, r_wdata, r_other;
  logic [2:0]  r_wdest;
  logic        r_rd, r_wr, r_wen, r_wsel, r_err_to, r_err_mis;

  logic w_accept, w_misalign, w_start, w_waiting, w_timeout;

  always_comb begin
    w_accept   = (r_state == IDLE) & req_valid;
    w_misalign = w_accept & (req_addr[1:0] != 2'b00);
    w_start    = w_accept & ~w_misalign;
    w_waiting  = (r_state == RD_WAIT) | (r_state == WR_WAIT);
    // ack in the limit cycle wins over the timeout
    w_timeout  = w_waiting & ~mem_ack & (r_cnt == LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = req_write ? WR_WAIT : RD_WAIT;
      RD_WAIT: if (mem_ack) w_next = WB;
               else if (w_timeout) w_next = IDLE;
      WR_WAIT: if (mem_ack | w_timeout) w_next = IDLE;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_dest    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_other   <= '0;
      r_wdest   <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_wen     <= 1'b0;
      r_wsel    <= 1'b0;
      r_err_to  <= 1'b0;
      r_err_mis <= 1'b0;
    end else begin
      r_err_mis <= w_misalign;
      r_err_to  <= w_timeout;
      r_wen     <= 1'b0;
      r_wsel    <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          r_addr <= req_addr;
          r_dest <= req_dest;
          r_cnt  <= '0;
          if (req_write) begin
            r_wr    <= 1'b1;
            r_wdata <= req_wdata;
          end else begin
            r_rd <= 1'b1;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ack) begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
            // write-back regs load on entry to WB so they are live during WB
            if (r_state == RD_WAIT) begin
              r_wen   <= 1'b1;
              r_wsel  <= 1'b1;
              r_wdest <= r_dest;
              r_other <= data_memory_in_v;
            end
          end else if (w_timeout) begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
          end else if (r_cnt != 4'hF) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready         = (r_state == IDLE);
  assign stall             = req_valid & (r_state != IDLE);
  assign data_memory_a     = r_addr;
  assign data_memory_out_v = r_wdata;
  assign data_memory_read  = r_rd;
  assign data_memory_write = r_wr;
  assign w_enable          = r_wen;
  assign w_select          = r_wsel;
  assign w_dest            = r_wdest;
  assign w_other           = r_other;
  assign err_timeout       = r_err_to;
  assign err_misalign      = r_err_mis;

endmodule

// File: tb/tb_ldst_sequencer.sv
// Bench for ldst_sequencer: scoreboard of expected write-back / error events
// pushed at request time and popped by a monitor when the DUT pulses them.
module tb_ldst_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_dest;
  logic        req_ready, stall;
  logic [31:0] data_memory_a, data_memory_out_v, data_memory_in_v;
  logic        data_memory_read, data_memory_write, mem_ack;
  logic        w_enable, w_select;
  logic [2:0]  w_dest;
  logic [31:0] w_other;
  logic        err_timeout, err_misalign;

  always #5 clk = ~clk;

  ldst_sequencer #(.MAX_WAIT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_dest(req_dest), .req_ready(req_ready),
    .stall(stall), .data_memory_a(data_memory_a),
    .data_memory_out_v(data_memory_out_v), .data_memory_read(data_memory_read),
    .data_memory_write(data_memory_write), .data_memory_in_v(data_memory_in_v),
    .mem_ack(mem_ack), .w_enable(w_enable), .w_select(w_select),
    .w_dest(w_dest), .w_other(w_other), .err_timeout(err_timeout),
    .err_misalign(err_misalign)
  );

  typedef struct {
    int          kind;   // 0 write-back, 1 timeout, 2 misalign
    logic [2:0]  dest;
    logic [31:0] data;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    chk("sb_nonempty", 64'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ev_kind", 64'(kind), 64'(e.kind));
      if (kind == 0 && e.kind == 0) begin
        chk("wb_dest", 64'(w_dest), 64'(e.dest));
        chk("wb_data", 64'(w_other), 64'(e.data));
        chk("wb_sel", 64'(w_select), 1);
      end
    end
  endtask

  // monitor: every event pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (w_enable)     pop_cmp(0);
      if (err_timeout)  pop_cmp(1);
      if (err_misalign) pop_cmp(2);
    end
  end

  // ack_at: strobe cycle (1-based) in which mem_ack is driven; 0 = never
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] dest, input int ack_at, input logic [31:0] rdata);
    bit mis;
    int n;
    int exp_n;
    ev_t e;
    mis = (addr[1:0] != 2'b00);
    @(negedge clk);
    chk("ready_at_req", 64'(req_ready), 1);
    e.dest = dest;
    e.data = rdata;
    if (mis)                            begin e.kind = 2; sb.push_back(e); end
    else if (ack_at == 0 || ack_at > 16) begin e.kind = 1; sb.push_back(e); end
    else if (!wr)                       begin e.kind = 0; sb.push_back(e); end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_dest = dest;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (data_memory_read | data_memory_write) begin
        n++;
        chk("strobe_kind", {data_memory_write, data_memory_read}, wr ? 2'b10 : 2'b01);
        chk("addr_stable", 64'(data_memory_a), 64'(addr));
        if (wr) chk("wdata_stable", 64'(data_memory_out_v), 64'(wdata));
        if (n == 1) chk("busy_ready", 64'(req_ready), 0);
        mem_ack = (n == ack_at);
        data_memory_in_v = rdata;
      end else begin
        mem_ack = 1'b0;
        if (mis) chk("mis_ready", 64'(req_ready), 1);
        if (n > 0 || (mis && c >= 2)) break;
      end
    end
    exp_n = mis ? 0 : ((ack_at == 0 || ack_at > 16) ? 16 : ack_at);
    chk("strobe_cycles", 64'(n), 64'(exp_n));
    if (!mis && !wr && ack_at != 0 && ack_at <= 16)
      chk("wb_follows_ack", 64'(w_enable), 1);
    #1;
    chk("sb_drained", 64'(sb.size()), 0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_dest = '0; mem_ack = 1'b0; data_memory_in_v = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {data_memory_read, data_memory_write, w_enable, w_select,
                     err_timeout, err_misalign, stall}, 0);
    chk("rst_addr", 64'(data_memory_a), 0);
    chk("rst_wdata", 64'(data_memory_out_v), 0);
    chk("rst_wb", {w_dest, w_other}, 0);
    chk("rst_ready", 64'(req_ready), 1);
    reset_n = 1'b1;

    txn(1'b0, 32'h0000_0010, 32'h0, 3'd3, 1, 32'hDEAD_BEEF);   // load, immediate ack
    txn(1'b1, 32'h0000_0040, 32'h1234_5678, 3'd0, 4, 32'h0);   // store, 4 wait cycles
    txn(1'b0, 32'h0000_0020, 32'h0, 3'd1, 0, 32'h0);           // timeout
    txn(1'b0, 32'h0000_0013, 32'h0, 3'd2, 1, 32'h0);           // misaligned
    txn(1'b0, 32'h0000_0024, 32'h0, 3'd5, 16, 32'hCAFE_F00D);  // ack at the limit
    txn(1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 3'd0, 1, 32'h0);   // back-to-back store
    txn(1'b0, 32'h0000_0104, 32'h0, 3'd7, 2, 32'h0BAD_C0DE);   // then load
    txn(1'b1, 32'h0000_0202, 32'h1, 3'd0, 1, 32'h0);           // misaligned store

    // reset in the middle of a read: strobe drops, late ack is ignored
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0080; req_dest = 3'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rd_wait2_strobe", 64'(data_memory_read), 1);
    req_valid = 1'b1; #1;
    chk("stall_busy", 64'(stall), 1);
    req_valid = 1'b0; #1;
    chk("stall_novalid", 64'(stall), 0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_strobe", 64'(data_memory_read), 0);
    reset_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; data_memory_in_v = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_wb", {w_enable, data_memory_read, err_timeout}, 0);
    chk("rst_ready_back", 64'(req_ready), 1);
    chk("sb_final", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/ldst_sequencer.md
# ldst_sequencer

Multi-cycle load/store controller between the execute stage and the single-port data memory. It accepts one load or store request from EX at a time and drives the data-memory address, data and strobes as registered outputs. It holds the request until the memory acknowledges or a timeout expires, and for loads issues a one-cycle register-file write-back. While a transaction is in flight it stalls the pipeline.

## Interface
Parameters:
- `MAX_WAIT`, default 15: wait cycles allowed after strobe assertion before abort; range 1–15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset; synchronous, active-low. One clock; no other clock domains.
- `req_valid`  in  1  EX presents a load/store request.
- `req_write`  in  1  1 = STORE, 0 = LOAD.
- `req_addr`  in  32  effective address, already computed as base register + immediate.
- `req_wdata`  in  32  store data.
- `req_dest`  in  3  destination register for a load.
- `req_ready`  out  1  request accepted this cycle when `req_valid & req_ready`.
- `stall`  out  1  pipeline hold.
- `data_memory_a`  out  32  memory address.
- `data_memory_out_v`  out  32  memory write data.
- `data_memory_read`  out  1  read strobe.
- `data_memory_write`  out  1  write strobe.
- `data_memory_in_v`  in  32  memory read data; valid when `mem_ack` is high.
- `mem_ack`  in  1  memory completion.
- `w_enable`  out  1  register-file write enable.
- `w_select`  out  1  write-back mux select; 1 = other (non-ALU) source.
- `w_dest`  out  3  register-file write address.
- `w_other`  out  32  load data to the register file.
- `err_timeout`  out  1  one-cycle pulse: transaction aborted.
- `err_misalign`  out  1  one-cycle pulse: request rejected.

## Operation
FSM states: IDLE, RD_WAIT, WR_WAIT, WB.

- **IDLE**
  - `req_ready=1`.
  - On accept with `req_addr[1:0]!=0`: pulse `err_misalign` next cycle, issue no strobe, stay in IDLE.
  - On aligned accept: register addr, wdata and dest. Go to RD_WAIT (`data_memory_read=1`) or WR_WAIT (`data_memory_write=1`, `data_memory_out_v=req_wdata`). Clear the wait counter.
- **RD_WAIT**
  - Strobe held high, address stable.
  - On `mem_ack`: capture `data_memory_in_v`, go to WB.
  - Otherwise increment the 4-bit counter. When the counter reaches `MAX_WAIT` without ack: drop the strobe, pulse `err_timeout`, go to IDLE with no write-back.
- **WR_WAIT**
  - Same as RD_WAIT, except `mem_ack` goes to IDLE. A store never writes the register file.
- **WB**
  - Drive `w_enable=1`, `w_select=1`, `w_dest` = captured dest, `w_other` = captured data for exactly one cycle, then go to IDLE.
- **Outputs**
  - `stall = req_valid & (state != IDLE)`, combinational.
  - `req_ready = (state == IDLE)`.
- **Strobes**
  - `data_memory_read` and `data_memory_write` are never high together.
  - Both drop in the cycle after `mem_ack` is sampled.
- **Spurious ack:** `mem_ack` in IDLE or WB is ignored.
- **Ack at the limit:** `mem_ack` in the same cycle the counter reaches `MAX_WAIT` counts as success; ack wins over timeout.
- **Counter:** saturates and never wraps. Counter width is 4 bits.
- **Reset values**, when `reset_n` is low at an edge:
  - State goes to IDLE.
  - All strobes, `w_enable`, `w_select`, `err_*`, `data_memory_a`, `data_memory_out_v`, `w_dest` and `w_other` go to 0.
  - Reset in mid-transaction drops the strobes at that edge. The pending load is discarded with no write-back.

## Timing
- **Accept at edge N:** strobe and address are valid from N+1.
- **Minimum load:** ack sampled at N+1, WB at N+2, `req_ready` again at N+3. That is 3 cycles accept-to-accept.
- **Minimum store:** ack at N+1, IDLE at N+2. That is 2 cycles.
- **Timeout:** strobe high for `MAX_WAIT`+1 cycles, `err_timeout` on the cycle after, IDLE.
- **Back-to-back:** a new request is accepted in the first IDLE cycle after completion. There are no bubbles beyond those above.
- **Register timing:** all outputs except `stall` and `req_ready` are registered.

## Test plan
- **Load, immediate ack:** load addr 0x0000_0010, dest 3; ack at N+1 with data 0xDEAD_BEEF → `data_memory_read` high 1 cycle; at N+2 `w_enable=1`, `w_dest=3`, `w_other=0xDEAD_BEEF`; `req_ready=1` at N+3.
- **Store with wait states:** store 0x1234_5678 to 0x0000_0040; ack after 4 cycles → `data_memory_write` high exactly 4 cycles with stable addr/data; `w_enable` never asserted.
- **Timeout:** load with `MAX_WAIT`=15 and no ack → strobe high 16 cycles, single `err_timeout` pulse, no write-back, `req_ready` returns.
- **Misaligned:** load to 0x0000_0013 → no strobe, one `err_misalign` pulse, `req_ready` stays 1.
- **Reset mid-read:** assert `reset_n`=0 during RD_WAIT cycle 2 → strobe 0 after the edge, then the late ack is ignored and there is no write-back.
- **Ack at the limit:** ack coincides with the final wait cycle → load completes normally and `err_timeout` stays 0.
